// File: rtl/switch_debounce_pkg.sv
// ----------------------------------------------------------------------------
// switch_debounce_pkg
//
// Purpose : Shared defaults and helpers for the switch debouncer slice.
//           Holds the default switch count and debounce interval, the
//           per-bit counter width helper, and the classification used by the
//           per-bit counter logic.
//
// Contents:
//   DEFAULT_NUM_SW          - default number of switch inputs (10)
//   DEFAULT_DEBOUNCE_CYCLES - default stable interval in clk cycles
//                             (500000 = 10 ms at 50 MHz)
//   cnt_class_e             - per-cycle decision of a debounce counter
//   cnt_width()             - counter width for a given debounce interval
// ----------------------------------------------------------------------------
package switch_debounce_pkg;

  localparam int DEFAULT_NUM_SW          = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  // What a bit's counter does on the coming edge.
  typedef enum logic [1:0] {
    CNT_IDLE   = 2'b00,  // synchronized input agrees with accepted level
    CNT_RUN    = 2'b01,  // disagreement, interval not yet complete
    CNT_ACCEPT = 2'b10   // disagreement held for the full interval
  } cnt_class_e;

  // Counter width for an interval of 'cycles' clocks. The counter only has
  // to reach cycles-1, so $clog2(cycles) bits suffice; never return 0 so a
  // degenerate interval still yields a legal vector.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage : switch_debounce_pkg

// File: rtl/switch_debounce_cell.sv
// ----------------------------------------------------------------------------
// switch_debounce_cell
//
// Purpose : Debounces one raw switch pin. The pin is brought into the clk
//           domain by a two-flop synchronizer, then a private counter
//           measures how long the synchronized level has disagreed with the
//           accepted level. Only after DEBOUNCE_CYCLES consecutive
//           disagreeing cycles is the new level accepted.
//
// Optional: `SWITCH_DEBOUNCE_EDGE_EN adds registered rise/fall strobes and a
//           sticky changed flag with a synchronous per-bit clear.
//
// Ports   :
//   clk           in  - sole clock, rising edge
//   reset_n       in  - asynchronous active-low reset
//   sw_raw_i      in  - raw asynchronous switch pin
//   sw_out_o      out - accepted (debounced) level, registered
//   clr_changed_i in  - clear for changed_o          (edge build only)
//   rise_o        out - one-cycle 0->1 strobe        (edge build only)
//   fall_o        out - one-cycle 1->0 strobe        (edge build only)
//   changed_o     out - sticky change flag           (edge build only)
// ----------------------------------------------------------------------------
module switch_debounce_cell
  import switch_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw_i,
  output logic sw_out_o
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  input  logic clr_changed_i,
  output logic rise_o,
  output logic fall_o,
  output logic changed_o
`endif
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept_s;
  cnt_class_e    cls_s;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Classify the cycle and compute the next counter and accepted level.
  // Acceptance happens on the edge where the counter already sits at
  // DEBOUNCE_CYCLES-1, so the counter can never wrap.
  always_comb begin
    cnt_d    = cnt_q;
    level_d  = level_q;
    accept_s = 1'b0;
    if (sync2_q == level_q) begin
      cls_s = CNT_IDLE;
    end else if (cnt_q == CNT_MAX) begin
      cls_s = CNT_ACCEPT;
    end else begin
      cls_s = CNT_RUN;
    end
    case (cls_s)
      CNT_IDLE: begin
        cnt_d = '0;
      end
      CNT_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
      end
      CNT_ACCEPT: begin
        cnt_d    = '0;
        level_d  = sync2_q;
        accept_s = 1'b1;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Counter and accepted-level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign sw_out_o = level_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic rise_d;
  logic fall_q;
  logic fall_d;
  logic changed_q;
  logic changed_d;

  // Strobes are derived from the acceptance decision so they assert on the
  // same edge that sw_out_o moves; set of changed wins over its clear.
  always_comb begin
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    changed_d = changed_q;
    if (accept_s) begin
      rise_d    = sync2_q;
      fall_d    = ~sync2_q;
      changed_d = 1'b1;
    end else if (clr_changed_i) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  // Edge strobe and sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;
`endif

endmodule : switch_debounce_cell

// File: rtl/switch_debouncer.sv
// ----------------------------------------------------------------------------
// switch_debouncer
//
// Purpose : Debounces NUM_SW independent mechanical switches for the switch
//           PIO. Each bit has its own synchronizer and counter (see
//           switch_debounce_cell); a stable level on sw_raw shows up on
//           sw_out DEBOUNCE_CYCLES+2 clk edges after it is first sampled.
//
// Optional: define SWITCH_DEBOUNCE_EDGE_EN to add rise_pulse, fall_pulse,
//           changed and clr_changed. Without it those ports and their flops
//           do not exist and sw_out behaves identically.
//
// Parameters:
//   NUM_SW          - number of switches, 1..32
//   DEBOUNCE_CYCLES - stable clk cycles before acceptance, 2..2^24
//
// Ports   :
//   clk         in  - sole clock, rising edge
//   reset_n     in  - asynchronous active-low reset
//   sw_raw      in  - raw asynchronous switch pins [NUM_SW]
//   sw_out      out - debounced levels, registered [NUM_SW]
//   rise_pulse  out - per-bit 0->1 strobe          (edge build only)
//   fall_pulse  out - per-bit 1->0 strobe          (edge build only)
//   changed     out - per-bit sticky change flag   (edge build only)
//   clr_changed in  - per-bit clear of changed     (edge build only)
// ----------------------------------------------------------------------------
module switch_debouncer
  import switch_debounce_pkg::*;
#(
  parameter int NUM_SW          = DEFAULT_NUM_SW,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_out
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [NUM_SW-1:0] rise_pulse,
  output logic [NUM_SW-1:0] fall_pulse,
  output logic [NUM_SW-1:0] changed,
  input  logic [NUM_SW-1:0] clr_changed
`endif
);

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_cell
    switch_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk           (clk),
      .reset_n       (reset_n),
      .sw_raw_i      (sw_raw[gi]),
      .sw_out_o      (sw_out[gi])
`ifdef SWITCH_DEBOUNCE_EDGE_EN
      ,
      .clr_changed_i (clr_changed[gi]),
      .rise_o        (rise_pulse[gi]),
      .fall_o        (fall_pulse[gi]),
      .changed_o     (changed[gi])
`endif
    );
  end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// ----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed bench for switch_debouncer with NUM_SW=10, DEBOUNCE_CYCLES=8.
// The stimulus process pushes the expected output events (cycle, sw_out and,
// in the edge build, the strobes and changed flags) into a queue. A monitor
// pops one entry every time the observed output vector changes and compares.
// Edge-related checks are active when SWITCH_DEBOUNCE_EDGE_EN is defined.
// ----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int NSW = 10;
  localparam int DC  = 8;
  localparam int LAT = DC + 2;

  typedef struct {
    int         cyc;
    logic [9:0] sw;
    logic [9:0] rise;
    logic [9:0] fall;
    logic [9:0] chg;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] sw_out;
  logic [NSW-1:0] rise_pulse;
  logic [NSW-1:0] fall_pulse;
  logic [NSW-1:0] changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [NSW-1:0] clr_changed;
`endif

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  exp_t sb_q[$];
  logic [39:0] prev_vec = '0;

  switch_debouncer #(
    .NUM_SW          (NSW),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_raw      (sw_raw),
    .sw_out      (sw_out)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .changed     (changed),
    .clr_changed (clr_changed)
`endif
  );

`ifndef SWITCH_DEBOUNCE_EDGE_EN
  assign rise_pulse = '0;
  assign fall_pulse = '0;
  assign changed    = '0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected acceptance event plus, with strobes present, the strobe drop.
  task automatic push_acc(input int c, input logic [9:0] sw, input logic [9:0] rise,
                          input logic [9:0] fall, input logic [9:0] chg);
    exp_t e;
    e.cyc = c; e.sw = sw; e.rise = rise; e.fall = fall; e.chg = chg;
    sb_q.push_back(e);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    e.cyc = c + 1; e.rise = '0; e.fall = '0;
    sb_q.push_back(e);
`endif
  endtask

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  // Drive a one-cycle clear and expect changed to drop on the next edge.
  task automatic clear_changed(input logic [9:0] mask, input logic [9:0] sw,
                               input logic [9:0] chg_after);
    exp_t e;
    e.cyc = cyc + 1; e.sw = sw; e.rise = '0; e.fall = '0; e.chg = chg_after;
    sb_q.push_back(e);
    clr_changed = mask;
    @(negedge clk);
    clr_changed = '0;
    repeat (3) @(negedge clk);
  endtask
`endif

  // Monitor: every change of the output vector consumes one expected event.
  always @(negedge clk) begin
    logic [39:0] vec;
    exp_t        e;
    vec = {sw_out, rise_pulse, fall_pulse, changed};
    if (mon_en && (vec !== prev_vec)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d sw_out=0x%03h rise=0x%03h fall=0x%03h changed=0x%03h, expected no change",
                 cyc, sw_out, rise_pulse, fall_pulse, changed);
      end else begin
        e = sb_q.pop_front();
        check_int("event_cycle", cyc, e.cyc);
        check("sw_out", sw_out, e.sw);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        check("rise_pulse", rise_pulse, e.rise);
        check("fall_pulse", fall_pulse, e.fall);
        check("changed", changed, e.chg);
`endif
      end
    end
    prev_vec = vec;
  end

  initial begin
    int c;
    int r;
    reset_n = 1'b0;
    sw_raw  = '0;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    clr_changed = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_sw_out", sw_out, 10'h000);
    check("reset_changed", changed, 10'h000);
    check("reset_rise", rise_pulse, 10'h000);
    check("reset_fall", fall_pulse, 10'h000);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_sw_out", sw_out, 10'h000);

    // Single bit rise, accepted LAT edges after first sample.
    c = cyc;
    sw_raw = 10'h001;
    push_acc(c + LAT, 10'h001, 10'h001, 10'h000, 10'h001);
    repeat (14) @(negedge clk);

    // Seven-cycle glitch on bit 3 must be rejected.
    sw_raw = 10'h009;
    repeat (7) @(negedge clk);
    sw_raw = 10'h001;
    repeat (14) @(negedge clk);
    check("glitch_sw_out", sw_out, 10'h001);

    // Held level on bit 3 is accepted.
    c = cyc;
    sw_raw = 10'h009;
    push_acc(c + LAT, 10'h009, 10'h008, 10'h000, 10'h009);
    repeat (14) @(negedge clk);

    // Two bits falling together.
    c = cyc;
    sw_raw = 10'h000;
    push_acc(c + LAT, 10'h000, 10'h000, 10'h009, 10'h009);
    repeat (14) @(negedge clk);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    clear_changed(10'h3FF, 10'h000, 10'h000);
`endif

    // All ten bits rise in the same cycle.
    c = cyc;
    sw_raw = 10'h3FF;
    push_acc(c + LAT, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF);
    repeat (14) @(negedge clk);

    // Only bit 9 falls.
    c = cyc;
    sw_raw = 10'h1FF;
    push_acc(c + LAT, 10'h1FF, 10'h000, 10'h200, 10'h3FF);
    repeat (14) @(negedge clk);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    clear_changed(10'h3FF, 10'h1FF, 10'h000);
`endif

    // Bit 0 falls with its clear on the acceptance edge: set wins.
    c = cyc;
    sw_raw = 10'h1FE;
    push_acc(c + LAT, 10'h1FE, 10'h000, 10'h001, 10'h001);
    repeat (LAT - 1) @(negedge clk);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    clr_changed = 10'h001;
    @(negedge clk);
    clr_changed = '0;
`else
    @(negedge clk);
`endif
    repeat (13) @(negedge clk);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    clear_changed(10'h001, 10'h1FE, 10'h000);
`endif

    // Staggered transitions on bits 1 and 2 keep their own schedules.
    c = cyc;
    sw_raw = 10'h1FC;
    push_acc(c + LAT, 10'h1FC, 10'h000, 10'h002, 10'h002);
    repeat (3) @(negedge clk);
    sw_raw = 10'h1F8;
    push_acc(c + 3 + LAT, 10'h1F8, 10'h000, 10'h004, 10'h006);
    repeat (14) @(negedge clk);

    // Reset mid-count (counter at 5) clears everything immediately.
    sw_raw = 10'h1F9;
    repeat (7) @(negedge clk);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_sw_out", sw_out, 10'h000);
    check("midreset_changed", changed, 10'h000);
    check("midreset_rise", rise_pulse, 10'h000);
    check("midreset_fall", fall_pulse, 10'h000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    r = cyc;
    push_acc(r + LAT, 10'h1F9, 10'h1F9, 10'h000, 10'h1F9);
    mon_en = 1'b1;
    repeat (16) @(negedge clk);

    // Every expected event must have been observed.
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_switch_debouncer
